// File: rtl/demux1_2_reg_if.sv
// Valid/ready bundle for the registered 1:2 demultiplexer:
// one producer port and two sink ports.
interface demux1_2_reg_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output in_sel,
        input  a_valid,
        output a_ready,
        input  a_data,
        input  b_valid,
        output b_ready,
        input  b_data
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_sel,
        output a_valid,
        input  a_ready,
        output a_data,
        output b_valid,
        input  b_ready,
        output b_data
    );
endinterface

// File: rtl/demux1_2_reg.sv
// Registered 1:2 demux with a 2-entry in-order skid buffer.
// Optional pop counters per sink when DEMUX1_2_STATS_EN is defined.
module demux1_2_reg #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    demux1_2_reg_if.slave bus
`ifdef DEMUX1_2_STATS_EN
    ,
    output logic [15:0]   cnt_a,
    output logic [15:0]   cnt_b
`endif
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] head_data_q;
    logic [WIDTH-1:0] head_data_d;
    logic             head_sel_q;
    logic             head_sel_d;
    logic [WIDTH-1:0] skid_data_q;
    logic [WIDTH-1:0] skid_data_d;
    logic             skid_sel_q;
    logic             skid_sel_d;
    logic             live_q;
    logic             live_d;

    logic head_vld;
    logic push;
    logic pop;

    // in_ready is held low until the first edge after reset release
    assign head_vld     = (state_q != S_EMPTY);
    assign bus.in_ready = live_q & (state_q != S_TWO);

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = head_vld
                & (head_sel_q ? bus.b_ready : bus.a_ready);

    assign bus.a_valid = head_vld & ~head_sel_q;
    assign bus.b_valid = head_vld & head_sel_q;
    assign bus.a_data  = bus.a_valid ? head_data_q : '0;
    assign bus.b_data  = bus.b_valid ? head_data_q : '0;

    always_comb begin
        live_d      = 1'b1;
        state_d     = state_q;
        head_data_d = head_data_q;
        head_sel_d  = head_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        unique case (state_q)
            S_EMPTY: begin
                if (push) begin
                    state_d     = S_ONE;
                    head_data_d = bus.in_data;
                    head_sel_d  = bus.in_sel;
                end
            end
            S_ONE: begin
                if (push && pop) begin
                    head_data_d = bus.in_data;
                    head_sel_d  = bus.in_sel;
                end else if (push) begin
                    state_d     = S_TWO;
                    skid_data_d = bus.in_data;
                    skid_sel_d  = bus.in_sel;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    state_d     = S_ONE;
                    head_data_d = skid_data_q;
                    head_sel_d  = skid_sel_q;
                    skid_data_d = '0;
                    skid_sel_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q      <= 1'b0;
            state_q     <= S_EMPTY;
            head_data_q <= '0;
            head_sel_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sel_q  <= 1'b0;
        end else begin
            live_q      <= live_d;
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_sel_q  <= head_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
        end
    end

`ifdef DEMUX1_2_STATS_EN
    logic [15:0] cnt_a_q;
    logic [15:0] cnt_a_d;
    logic [15:0] cnt_b_q;
    logic [15:0] cnt_b_d;

    // Saturating per-sink pop counters
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (pop && !head_sel_q && cnt_a_q != 16'hFFFF) begin
            cnt_a_d = cnt_a_q + 16'd1;
        end
        if (pop && head_sel_q && cnt_b_q != 16'hFFFF) begin
            cnt_b_d = cnt_b_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_demux1_2_reg.sv
// Self-checking bench for demux1_2_reg: directed steps plus a
// scoreboard queue that models occupancy, order and in_ready.
module tb_demux1_2_reg;

    logic clk;
    logic rst_n;

    demux1_2_reg_if #(.WIDTH(32)) bus ();

`ifdef DEMUX1_2_STATS_EN
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
`endif

    demux1_2_reg #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DEMUX1_2_STATS_EN
        ,
        .cnt_a (cnt_a),
        .cnt_b (cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard entry: {sel, data}
    logic [32:0] sb[$];
    logic        armed;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed = 1'b0;
        else        armed = 1'b1;
    end

    always @(negedge rst_n) sb.delete();

    always @(negedge clk) begin
        logic        exp_rdy;
        logic        exp_av;
        logic        exp_bv;
        logic [31:0] exp_d;
        exp_rdy = armed && (sb.size() < 2) && rst_n;
        exp_av  = (sb.size() != 0) && !sb[0][32];
        exp_bv  = (sb.size() != 0) && sb[0][32];
        exp_d   = (sb.size() != 0) ? sb[0][31:0] : 32'h0;
        chk("mon_in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
        chk("mon_a_valid", {31'b0, bus.a_valid}, {31'b0, exp_av});
        chk("mon_b_valid", {31'b0, bus.b_valid}, {31'b0, exp_bv});
        chk("mon_a_data", bus.a_data, exp_av ? exp_d : 32'h0);
        chk("mon_b_data", bus.b_data, exp_bv ? exp_d : 32'h0);
        if ((exp_av && bus.a_ready) || (exp_bv && bus.b_ready))
            void'(sb.pop_front());
        if (bus.in_valid && exp_rdy)
            sb.push_back({bus.in_sel, bus.in_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s,
                         input logic [31:0] d);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;
        drive(1'b1, 1'b0, 32'hFFFF_FFFF);

        // Reset held with in_valid=1
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", {31'b0, bus.in_ready}, 32'h0);
            chk("rst_a_valid", {31'b0, bus.a_valid}, 32'h0);
            chk("rst_b_valid", {31'b0, bus.b_valid}, 32'h0);
            chk("rst_a_data", bus.a_data, 32'h0);
            chk("rst_b_data", bus.b_data, 32'h0);
        end
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rel_in_ready_pre", {31'b0, bus.in_ready}, 32'h0);
        tick();
        @(negedge clk);
        chk("rel_in_ready_post", {31'b0, bus.in_ready}, 32'h1);

        // Streaming with both sinks ready
        tick();
        drive(1'b1, 1'b0, 32'h0000_0001);
        tick();
        drive(1'b1, 1'b1, 32'h0000_0002);
        @(negedge clk);
        chk("str_a1_valid", {31'b0, bus.a_valid}, 32'h1);
        chk("str_a1_data", bus.a_data, 32'h1);
        tick();
        drive(1'b1, 1'b0, 32'h0000_0003);
        @(negedge clk);
        chk("str_b2_valid", {31'b0, bus.b_valid}, 32'h1);
        chk("str_b2_data", bus.b_data, 32'h2);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("str_a3_valid", {31'b0, bus.a_valid}, 32'h1);
        chk("str_a3_data", bus.a_data, 32'h3);
        tick();
        @(negedge clk);
        chk("str_empty", {30'b0, bus.a_valid, bus.b_valid}, 32'h0);

        // Backpressure fills both entries
        tick();
        bus.a_ready = 1'b0;
        drive(1'b1, 1'b0, 32'hDEAD_BEEF);
        tick();
        drive(1'b1, 1'b1, 32'hCAFE_F00D);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("full_in_ready", {31'b0, bus.in_ready}, 32'h0);
            chk("full_b_valid", {31'b0, bus.b_valid}, 32'h0);
            chk("full_a_data", bus.a_data, 32'hDEAD_BEEF);
            tick();
        end
        bus.a_ready = 1'b1;
        tick();
        bus.b_ready = 1'b1;
        drive(1'b1, 1'b0, 32'h1234_5678);
        @(negedge clk);
        chk("drain_b_data", bus.b_data, 32'hCAFE_F00D);
        chk("drain_in_ready", {31'b0, bus.in_ready}, 32'h1);

        // Push and pop together in ONE
        tick();
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("pp_a_valid", {31'b0, bus.a_valid}, 32'h1);
        chk("pp_a_data", bus.a_data, 32'h1234_5678);
        chk("pp_b_valid", {31'b0, bus.b_valid}, 32'h0);
        tick();

        // Async reset with two entries held
        bus.a_ready = 1'b0;
        bus.b_ready = 1'b0;
        drive(1'b1, 1'b0, 32'hAAAA_0001);
        tick();
        drive(1'b1, 1'b1, 32'hBBBB_0002);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("ar_full_ready", {31'b0, bus.in_ready}, 32'h0);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_a_valid", {31'b0, bus.a_valid}, 32'h0);
        chk("ar_b_valid", {31'b0, bus.b_valid}, 32'h0);
        chk("ar_a_data", bus.a_data, 32'h0);
        chk("ar_in_ready", {31'b0, bus.in_ready}, 32'h0);
        tick();
        rst_n       = 1'b1;
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("ar_no_word", {30'b0, bus.a_valid, bus.b_valid}, 32'h0);
            tick();
        end
        drive(1'b1, 1'b1, 32'h5555_AAAA);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("ar_resume_b", bus.b_data, 32'h5555_AAAA);
        tick();

`ifdef DEMUX1_2_STATS_EN
        rst_n = 1'b0;
        #2;
        chk("st_rst_cnt_a", {16'b0, cnt_a}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 65537; i++) begin
            drive(1'b1, 1'b0, i);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0);
        tick();
        @(negedge clk);
        chk("st_cnt_a_sat", {16'b0, cnt_a}, 32'hFFFF);
        chk("st_cnt_b_zero", {16'b0, cnt_b}, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h0BAD_0001);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        tick();
        @(negedge clk);
        chk("st_cnt_b_one", {16'b0, cnt_b}, 32'h1);
        chk("st_cnt_a_hold", {16'b0, cnt_a}, 32'hFFFF);
        tick();
        rst_n = 1'b0;
        #2;
        chk("st_cnt_a_clr", {16'b0, cnt_a}, 32'h0);
        chk("st_cnt_b_clr", {16'b0, cnt_b}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
`endif

        @(negedge clk);
        chk("end_sb_empty", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
